// File: rtl/mac_stream.sv
// Pipelined multiply-accumulate over first/last framed packets.
// Stage 1 registers the product; stage 2 accumulates with optional saturation and emits the result.
module mac_stream #(
  parameter int A_W      = 8,
  parameter int B_W      = 8,
  parameter int ACC_W    = 24,
  parameter bit SIGNED   = 1'b0,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic [ACC_W-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] y,
  output logic             ovf
);

  localparam int P_W = A_W + B_W;

  if (ACC_W < P_W) begin : g_width_check
    $error("mac_stream: ACC_W must be >= A_W+B_W");
  end

  // Clamp value for an overflowing sum; neg selects the signed minimum.
  function automatic logic [ACC_W-1:0] sat_value(input logic neg);
    logic [ACC_W-1:0] v;
    if (!SIGNED) begin
      v = {ACC_W{1'b1}};
    end else if (neg) begin
      v = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      v = {1'b0, {(ACC_W-1){1'b1}}};
    end
    return v;
  endfunction

  logic             en_s;
  logic             accept_s;
  logic [P_W-1:0]   a_ext_s;
  logic [P_W-1:0]   b_ext_s;
  logic [P_W-1:0]   prod_s;
  logic             s1_valid_r;
  logic             s1_first_r;
  logic             s1_last_r;
  logic [P_W-1:0]   p_r;
  logic [ACC_W-1:0] s1_c_r;
  logic [ACC_W-1:0] acc_r;
  logic             pkt_ovf_r;
  logic [ACC_W-1:0] base_s;
  logic [ACC_W-1:0] p_ext_s;
  logic [ACC_W:0]   sum_s;
  logic             beat_ovf_s;
  logic [ACC_W-1:0] acc_next_s;
  logic             pkt_next_s;

  // Handshake and product: operands are extended to the full product width, so the low P_W bits are exact.
  always_comb begin
    en_s     = !(out_valid && !out_ready);
    in_ready = en_s && !rst;
    accept_s = in_valid && in_ready;
    if (SIGNED) begin
      a_ext_s = P_W'($signed(a));
      b_ext_s = P_W'($signed(b));
    end else begin
      a_ext_s = P_W'(a);
      b_ext_s = P_W'(b);
    end
    prod_s = a_ext_s * b_ext_s;
  end

  // Stage 1: multiply register plus beat framing and bias.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
      p_r        <= {P_W{1'b0}};
      s1_c_r     <= {ACC_W{1'b0}};
    end else if (en_s) begin
      s1_valid_r <= accept_s;
      s1_first_r <= in_first;
      s1_last_r  <= in_last;
      p_r        <= prod_s;
      s1_c_r     <= c;
    end
  end

  // Stage 2 arithmetic: one spare bit holds the unsigned carry.
  always_comb begin
    base_s = s1_first_r ? s1_c_r : acc_r;
    if (SIGNED) begin
      p_ext_s = ACC_W'($signed(p_r));
    end else begin
      p_ext_s = ACC_W'(p_r);
    end
    sum_s = {1'b0, base_s} + {1'b0, p_ext_s};
    if (SIGNED) begin
      beat_ovf_s = (base_s[ACC_W-1] == p_ext_s[ACC_W-1]) &&
                   (sum_s[ACC_W-1] != base_s[ACC_W-1]);
    end else begin
      beat_ovf_s = sum_s[ACC_W];
    end
    if (beat_ovf_s && SATURATE) begin
      acc_next_s = sat_value(base_s[ACC_W-1]);
    end else begin
      acc_next_s = sum_s[ACC_W-1:0];
    end
    pkt_next_s = (s1_first_r ? 1'b0 : pkt_ovf_r) | beat_ovf_s;
  end

  // Stage 2 state: accumulator, sticky packet overflow and the held output result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r     <= {ACC_W{1'b0}};
      pkt_ovf_r <= 1'b0;
      y         <= {ACC_W{1'b0}};
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (en_s && s1_valid_r) begin
        acc_r     <= acc_next_s;
        pkt_ovf_r <= pkt_next_s;
      end
      if (en_s && s1_valid_r && s1_last_r) begin
        y         <= acc_next_s;
        ovf       <= pkt_next_s;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
